// File: rtl/sha2_pkg.sv
// Shared types, rotation constants and word-slice helpers for the SHA-2 round engine.
package sha2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINAL
  } state_e;

  localparam int unsigned NWORDS = 8;

  localparam int unsigned SIG0_256_A = 2;
  localparam int unsigned SIG0_256_B = 13;
  localparam int unsigned SIG0_256_C = 22;
  localparam int unsigned SIG1_256_A = 6;
  localparam int unsigned SIG1_256_B = 11;
  localparam int unsigned SIG1_256_C = 25;

  localparam int unsigned SIG0_512_A = 28;
  localparam int unsigned SIG0_512_B = 34;
  localparam int unsigned SIG0_512_C = 39;
  localparam int unsigned SIG1_512_A = 14;
  localparam int unsigned SIG1_512_B = 18;
  localparam int unsigned SIG1_512_C = 41;

  // Word 0 (A) occupies the most significant slice of an 8*WIDTH bus.
  function automatic int unsigned word_lo(input int unsigned idx, input int unsigned width);
    return (NWORDS - 1 - idx) * width;
  endfunction

endpackage

// File: rtl/sha2_round_func.sv
// Combinational SHA-2 round: Ch, Ma, Sigma0, Sigma1 and the T1/T2 adders.
module sha2_round_func
  import sha2_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [WIDTH-1:0] e_i,
  input  logic [WIDTH-1:0] f_i,
  input  logic [WIDTH-1:0] g_i,
  input  logic [WIDTH-1:0] h_i,
  input  logic [WIDTH-1:0] w_i,
  input  logic [WIDTH-1:0] k_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] e_o
);

  localparam int unsigned S0A = (WIDTH == 64) ? SIG0_512_A : SIG0_256_A;
  localparam int unsigned S0B = (WIDTH == 64) ? SIG0_512_B : SIG0_256_B;
  localparam int unsigned S0C = (WIDTH == 64) ? SIG0_512_C : SIG0_256_C;
  localparam int unsigned S1A = (WIDTH == 64) ? SIG1_512_A : SIG1_256_A;
  localparam int unsigned S1B = (WIDTH == 64) ? SIG1_512_B : SIG1_256_B;
  localparam int unsigned S1C = (WIDTH == 64) ? SIG1_512_C : SIG1_256_C;

  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WIDTH - n));
  endfunction

  logic [WIDTH-1:0] sum0, sum1, ch, maj, t1, t2;

  always_comb begin
    sum0 = rotr(a_i, S0A) ^ rotr(a_i, S0B) ^ rotr(a_i, S0C);
    sum1 = rotr(e_i, S1A) ^ rotr(e_i, S1B) ^ rotr(e_i, S1C);
    ch   = (e_i & f_i) ^ (~e_i & g_i);
    maj  = (a_i & b_i) ^ (a_i & c_i) ^ (b_i & c_i);
    t1   = h_i + sum1 + ch + k_i + w_i;
    t2   = sum0 + maj;
    a_o  = t1 + t2;
    e_o  = d_i + t1;
  end

endmodule

// File: rtl/sha2_round_engine.sv
// Iterative SHA-2 compression core, one round per accepted W_t/K_t word.
// Define SHA2_FEEDFORWARD_EN to add the saved initial state into the result.
module sha2_round_engine
  import sha2_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ROUNDS = 64,
  parameter int unsigned CNT_W  = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [8*WIDTH-1:0]   init_state,
  input  logic                 wt_valid,
  output logic                 wt_ready,
  input  logic [WIDTH-1:0]     w_t,
  input  logic [WIDTH-1:0]     k_t,
  output logic                 busy,
  output logic [CNT_W-1:0]     round_cnt,
  output logic                 done,
  output logic [8*WIDTH-1:0]   state_out
);

  if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
    $error("sha2_round_engine: WIDTH must be 32 or 64");
  end
  if ((2 ** CNT_W) <= ROUNDS) begin : g_bad_cnt_w
    $error("sha2_round_engine: CNT_W too small for ROUNDS");
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS - 1);

  state_e             state_q;
  logic [WIDTH-1:0]   work_q [NWORDS];
  logic [CNT_W-1:0]   cnt_q;
  logic               ready_q;
  logic               busy_q;
  logic               done_q;
  logic [8*WIDTH-1:0] out_q;
  logic [WIDTH-1:0]   a_d;
  logic [WIDTH-1:0]   e_d;
  logic               fire;
`ifdef SHA2_FEEDFORWARD_EN
  logic [WIDTH-1:0]   init_q [NWORDS];
`endif

  assign fire = wt_valid && ready_q;

  sha2_round_func #(.WIDTH(WIDTH)) u_round (
    .a_i (work_q[0]),
    .b_i (work_q[1]),
    .c_i (work_q[2]),
    .d_i (work_q[3]),
    .e_i (work_q[4]),
    .f_i (work_q[5]),
    .g_i (work_q[6]),
    .h_i (work_q[7]),
    .w_i (w_t),
    .k_i (k_t),
    .a_o (a_d),
    .e_o (e_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      for (int unsigned i = 0; i < NWORDS; i++) begin
        work_q[i] <= '0;
`ifdef SHA2_FEEDFORWARD_EN
        init_q[i] <= '0;
`endif
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            for (int unsigned i = 0; i < NWORDS; i++) begin
              work_q[i] <= init_state[word_lo(i, WIDTH) +: WIDTH];
`ifdef SHA2_FEEDFORWARD_EN
              init_q[i] <= init_state[word_lo(i, WIDTH) +: WIDTH];
`endif
            end
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (fire) begin
            work_q[0] <= a_d;
            work_q[1] <= work_q[0];
            work_q[2] <= work_q[1];
            work_q[3] <= work_q[2];
            work_q[4] <= e_d;
            work_q[5] <= work_q[4];
            work_q[6] <= work_q[5];
            work_q[7] <= work_q[6];
            cnt_q     <= cnt_q + CNT_W'(1);
            // ready drops on the last transfer so no extra word is ever taken
            if (cnt_q == LAST_CNT) begin
              ready_q <= 1'b0;
              state_q <= FINAL;
            end
          end
        end
        FINAL: begin
          for (int unsigned i = 0; i < NWORDS; i++) begin
`ifdef SHA2_FEEDFORWARD_EN
            out_q[word_lo(i, WIDTH) +: WIDTH] <= work_q[i] + init_q[i];
`else
            out_q[word_lo(i, WIDTH) +: WIDTH] <= work_q[i];
`endif
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wt_ready  = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign round_cnt = cnt_q;
  assign state_out = out_q;

endmodule

// File: doc/sha2_round_engine.md
Name: sha2_round_engine

Overview:
- Iterative SHA-2 compression engine that applies the full round sequence (Ch, Ma, Sigma0, Sigma1, temp1/temp2 update) to eight working variables, one round per accepted schedule word.
- Generalises the stand-alone majority function into a sequential core parametrised for SHA-256 (32-bit words, 64 rounds) or SHA-512 (64-bit words, 80 rounds).
- Sits between the message-schedule generator, which streams W_t and K_t, and the hash-state register file.

Parameters:
- WIDTH, 32, word width; only 32 or 64 are legal. Any other value fails elaboration.
- ROUNDS, 64, rounds per block; 64 for WIDTH=32, 80 for WIDTH=64.
- CNT_W, 7, width of the round counter; must satisfy 2**CNT_W > ROUNDS.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a block; honoured only in IDLE.
- init_state  in  8*WIDTH  initial {A,B,C,D,E,F,G,H}, with A in the MSBs.
- wt_valid  in  1  w_t/k_t valid.
- wt_ready  out  1  engine accepts a round word this cycle.
- w_t  in  WIDTH  message schedule word for the current round.
- k_t  in  WIDTH  round constant for the current round.
- busy  out  1  high from the start accept until done.
- round_cnt  out  CNT_W  number of rounds completed in the current block.
- done  out  1  one-cycle pulse; result is valid.
- state_out  out  8*WIDTH  working variables, or the digest if the optional feature is enabled; same packing as init_state.

Behaviour:
- Reset (asynchronous, any state):
  - FSM goes to IDLE.
  - wt_ready=0, busy=0, done=0, round_cnt=0, state_out=0.
  - Internal A..H and the saved init copy are cleared.
- FSM states: IDLE, RUN, FINAL.
- IDLE:
  - On start=1: latch init_state into A..H and the saved copy, clear round_cnt, set busy=1, go to RUN on the next edge.
  - state_out keeps its previous result until a new start is accepted.
- RUN:
  - wt_ready=1.
  - Each cycle with wt_valid&&wt_ready performs exactly one round (mod 2**WIDTH arithmetic):
    - T1 = H + Sigma1(E) + Ch(E,F,G) + k_t + w_t
    - T2 = Sigma0(A) + Ma(A,B,C)
    - New values: H=G, G=F, F=E, E=D+T1, D=C, C=B, B=A, A=T1+T2.
  - round_cnt increments on each accepted round.
  - wt_valid=0 stalls the engine: no state change and no counter change.
  - The transfer that makes round_cnt==ROUNDS moves the FSM to FINAL. wt_ready drops in the same edge, so a (ROUNDS+1)-th word is never accepted.
- FINAL (one cycle):
  - state_out <= A..H, or the digest per the optional feature.
  - done=1 for exactly this cycle's registered output; busy drops together with done.
  - Return to IDLE.
- Latency: ROUNDS accepted transfers plus 2 cycles (start to RUN, FINAL) from start to done.
- start is ignored while busy; no restart and no error.
- start asserted in the same cycle that FINAL exits is ignored; start must come from IDLE.
- Rotation and shift amounts for Sigma0/Sigma1 are selected by WIDTH:
  - 32-bit: Sigma0 rotr 2/13/22, Sigma1 rotr 6/11/25.
  - 64-bit: Sigma0 rotr 28/34/39, Sigma1 rotr 14/18/41.
- Ma(x,y,z) = (x&y)^(x&z)^(y&z); Ch(x,y,z) = (x&y)^(~x&z).

Optional Feature:
- Macro: SHA2_FEEDFORWARD_EN.
- Defined: in FINAL, each output word = the saved init word + final working word (mod 2**WIDTH), giving the chained intermediate hash directly.
- Undefined: state_out = raw A..H after ROUNDS rounds, and the saved init copy is not synthesised.

Decomposition:
- Package sha2_pkg holds:
  - The state enum (IDLE/RUN/FINAL).
  - Rotation constants for 32/64-bit modes.
  - Word-slice index helpers for the 8*WIDTH packing.
- One combinational sub-module, sha2_round_func, parametrised by WIDTH:
  - Inputs: A..H, w_t, k_t.
  - Outputs: next A and next E.
  - Holds Ch, Ma, Sigma0, Sigma1 and the adders.
- sha2_round_engine owns the FSM, counter, registers and feed-forward.

Test Plan:
- Reset mid-RUN: assert rst after 10 rounds → all outputs 0 at once, FSM in IDLE, next start runs a fresh block correctly.
- Single round, WIDTH=32:
  - Stimulus: init_state = SHA-256 IV 6a09e667,bb67ae85,3c6ef372,a54ff53a,510e527f,9b05688c,1f83d9ab,5be0cd19; w_t=61626380, k_t=428a2f98.
  - Response after one transfer: internal A..H = 5d6aebcd,6a09e667,bb67ae85,3c6ef372,fa2a4622,510e527f,9b05688c,1f83d9ab; round_cnt=1.
- Full "abc" block with SHA2_FEEDFORWARD_EN, WIDTH=32, standard W/K streamed → done pulses once; state_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Stall handling: same block with wt_valid randomly low ~50% → identical digest; round_cnt frozen during stalls; latency = ROUNDS valid cycles + 2.
- Boundary and handshake:
  - After the 64th transfer, wt_ready=0 while wt_valid is held high, and no extra round occurs.
  - start pulsed while busy → ignored; busy and done timing unchanged.
- WIDTH=64, ROUNDS=80, "abc" SHA-512 block with feed-forward → state_out = ddaf35a1 93617aba cc417349 ae204131 12e6fa4e 89a97ea2 0a9eeee6 4b55d39a 2192992a 274fc1a8 36ba3c23 a3feebbd 454d4423 643ce80e 2a9ac94f a54ca49f.
